lc3_memory: RTL and testbench

LC3_MEMORY -- requirements
Module: lc3_memory

---
 rtl/lc3_memory.sv | 144 ++++++++++++++
 tb/tb_lc3_memory.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_memory.sv
// LC-3 memory subsystem: word RAM plus memory-mapped MCR at xFFFE, with a
// fixed wait-state handshake (memEN held until a one-cycle memRDY pulse).
module lc3_memory #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memEN,
    input  logic        memWE,
    input  logic [15:0] memory_addr,
    input  logic [15:0] memory_din,
    output logic [15:0] memory_dout,
    output logic        memRDY,
    output logic [15:0] MCR
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned CNT_W     = 4;
    localparam logic [DATA_W-1:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [DATA_W-1:0] MCR_RESET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cntNext;
    logic [DATA_W-1:0]   addrQ;
    logic [DATA_W-1:0]   dinQ;
    logic                weQ;
    logic [DATA_W-1:0]   reqAddr;
    logic [DATA_W-1:0]   reqDin;
    logic                reqWe;
    logic                accept;
    logic                commit;
    logic                isMcr;
    logic                isRam;
    logic                ramWe;
    logic [ADDR_W-1:0]   ramIdx;
    logic [DATA_W-1:0]   ramRdata;
    logic [DATA_W-1:0]   doutNext;
    logic [DATA_W-1:0]   mcrNext;
    logic                rdyNext;

    logic [DATA_W-1:0]   ram [DEPTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (memEN) nextState = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the acceptance edge, so the
    // request fields come straight from the ports while in IDLE.
    always_comb begin
        accept  = (state == IDLE) && memEN;
        commit  = !rst && (state != RESP) && (nextState == RESP);
        reqAddr = (state == IDLE) ? memory_addr : addrQ;
        reqDin  = (state == IDLE) ? memory_din  : dinQ;
        reqWe   = (state == IDLE) ? memWE       : weQ;
        isMcr   = (reqAddr == MCR_ADDR);
        isRam   = !isMcr && ((reqAddr >> ADDR_W) == '0);
        ramIdx  = reqAddr[ADDR_W-1:0];
        ramWe   = commit && reqWe && isRam;

        cntNext = cnt;
        if (accept) begin
            cntNext = CNT_W'(WAIT_STATES);
        end else if (state == WAIT) begin
            cntNext = cnt - CNT_W'(1);
        end

        rdyNext = commit;

        mcrNext = MCR;
        if (commit && reqWe && isMcr) begin
            mcrNext = reqDin;
        end

        doutNext = memory_dout;
        if (commit && !reqWe) begin
            if (isMcr) begin
                doutNext = MCR;
            end else if (isRam) begin
                doutNext = ramRdata;
            end else begin
                doutNext = '0;
            end
        end
    end

    assign ramRdata = ram[ramIdx];

    // Registered outputs and captured request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            addrQ       <= '0;
            dinQ        <= '0;
            weQ         <= 1'b0;
            memRDY      <= 1'b0;
            memory_dout <= '0;
            MCR         <= MCR_RESET;
        end else begin
            cnt         <= cntNext;
            memRDY      <= rdyNext;
            memory_dout <= doutNext;
            MCR         <= mcrNext;
            if (accept) begin
                addrQ <= memory_addr;
                dinQ  <= memory_din;
                weQ   <= memWE;
            end
        end
    end

    // RAM array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[ramIdx] <= reqDin;
        end
    end

endmodule

// File: tb/tb_lc3_memory.sv
// Directed bench for lc3_memory: a WAIT_STATES=2 instance and a zero-wait
// instance share stimulus; expected responses go through a scoreboard queue.
module tb_lc3_memory;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        memEN;
    logic        memWE;
    logic [15:0] memory_addr;
    logic [15:0] memory_din;
    logic [15:0] dout2;
    logic [15:0] mcr2;
    logic        rdy2;
    logic [15:0] dout0;
    logic [15:0] mcr0;
    logic        rdy0;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          rdyCyc;
        logic        isRead;
        logic [15:0] exp2;
        logic [15:0] exp0;
    } item_t;

    item_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_memory #(.ADDR_W(10), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE),
        .memory_addr(memory_addr), .memory_din(memory_din),
        .memory_dout(dout2), .memRDY(rdy2), .MCR(mcr2)
    );

    lc3_memory #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE),
        .memory_addr(memory_addr), .memory_din(memory_din),
        .memory_dout(dout0), .memRDY(rdy0), .MCR(mcr0)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request; the zero-wait instance answers right after acceptance
    task automatic startReq(input logic we, input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] e2, input logic [15:0] e0);
        item_t it;
        @(negedge clk);
        memEN       = 1'b1;
        memWE       = we;
        memory_addr = a;
        memory_din  = d;
        it.rdyCyc   = cyc + 1 + WS;
        it.isRead   = !we;
        it.exp2     = e2;
        it.exp0     = e0;
        sb.push_back(it);
        @(negedge clk);
        check("rdy0_pulse", 16'(rdy0), 16'h0001);
        if (!we) check("dout0", dout0, e0);
        memEN       = 1'b0;
        memWE       = ~we;
        memory_addr = 16'($urandom);
        memory_din  = 16'($urandom);
        @(negedge clk);
        check("rdy0_single", 16'(rdy0), 16'h0000);
    endtask

    task automatic waitPulse();
        item_t it;
        for (int i = 0; i < 20 && !rdy2; i++) @(negedge clk);
        if (!rdy2) begin
            check("rdy2_timeout", 16'(rdy2), 16'h0001);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        check("sb_nonempty", 16'(sb.size() != 0), 16'h0001);
        if (sb.size() == 0) return;
        it = sb.pop_front();
        check("rdy2_cycle", 16'(cyc), 16'(it.rdyCyc));
        if (it.isRead) check("dout2", dout2, it.exp2);
    endtask

    task automatic checkLow();
        @(negedge clk);
        check("rdy2_single", 16'(rdy2), 16'h0000);
    endtask

    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] e2, input logic [15:0] e0);
        startReq(we, a, d, e2, e0);
        waitPulse();
        checkLow();
    endtask

    initial begin
        item_t it;
        rst         = 1'b1;
        memEN       = 1'b0;
        memWE       = 1'b0;
        memory_addr = '0;
        memory_din  = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy2",  16'(rdy2), 16'h0000);
        check("rst_dout2", dout2, 16'h0000);
        check("rst_mcr2",  mcr2,  16'h8000);
        check("rst_rdy0",  16'(rdy0), 16'h0000);
        check("rst_dout0", dout0, 16'h0000);
        check("rst_mcr0",  mcr0,  16'h8000);
        rst = 1'b0;

        // Basic write then read
        access(1'b1, 16'h0005, 16'h1234, 16'h0000, 16'h0000);
        access(1'b0, 16'h0005, 16'h0000, 16'h1234, 16'h1234);
        access(1'b1, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000);

        // MCR writes stay possible with the clock-enable bit cleared
        access(1'b1, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000);
        check("mcr2_clear", mcr2, 16'h0000);
        check("mcr0_clear", mcr0, 16'h0000);
        access(1'b0, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000);
        access(1'b1, 16'hFFFE, 16'h8000, 16'h0000, 16'h0000);
        check("mcr2_set", mcr2, 16'h8000);
        check("mcr0_set", mcr0, 16'h8000);
        access(1'b0, 16'hFFFE, 16'h0000, 16'h8000, 16'h8000);

        // Out-of-range address must not alias onto x0000
        access(1'b1, 16'h0400, 16'hAAAA, 16'h0000, 16'h0000);
        access(1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h0000);
        access(1'b0, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF);

        // Back-to-back reads with memEN held through RESP
        access(1'b1, 16'h0001, 16'hA1A1, 16'h0000, 16'h0000);
        access(1'b1, 16'h0002, 16'hB2B2, 16'h0000, 16'h0000);
        @(negedge clk);
        memEN       = 1'b1;
        memWE       = 1'b0;
        memory_addr = 16'h0001;
        it.rdyCyc = cyc + 1 + WS; it.isRead = 1'b1; it.exp2 = 16'hA1A1; it.exp0 = 16'hA1A1;
        sb.push_back(it);
        waitPulse();
        memory_addr = 16'h0002;
        it.rdyCyc = cyc + 2 + WS; it.isRead = 1'b1; it.exp2 = 16'hB2B2; it.exp0 = 16'hB2B2;
        sb.push_back(it);
        checkLow();
        @(negedge clk);
        memEN       = 1'b0;
        memory_addr = 16'($urandom);
        waitPulse();
        checkLow();
        repeat (3) @(negedge clk);

        // Reset during the wait phase of a write
        access(1'b1, 16'h0010, 16'h1111, 16'h0000, 16'h0000);
        @(negedge clk);
        memEN       = 1'b1;
        memWE       = 1'b1;
        memory_addr = 16'h0010;
        memory_din  = 16'h5555;
        @(negedge clk);
        check("rdy0_commit", 16'(rdy0), 16'h0001);
        rst   = 1'b1;
        memEN = 1'b0;
        #1;
        check("rst_abort_rdy2", 16'(rdy2), 16'h0000);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_rdy2", 16'(rdy2), 16'h0000);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rdy2", 16'(rdy2), 16'h0000);
        end
        check("sb_drained", 16'(sb.size()), 16'h0000);
        access(1'b0, 16'h0010, 16'h0000, 16'h1111, 16'h5555);
        access(1'b0, 16'h0005, 16'h0000, 16'h1234, 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
